// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch controller.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_ADDR   = 2'b01;
  localparam logic [1:0] SEL_RS     = 2'b10;
  localparam logic [1:0] SEL_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10,
    HALT = 2'b11
  } state_e;

  // Branch outranks jumps: it belongs to the older instruction in EX.
  function automatic logic [1:0] sel_encode(input logic branch_taken,
                                             input logic jump_reg,
                                             input logic jump);
    if (branch_taken)  return SEL_BRANCH;
    else if (jump_reg) return SEL_RS;
    else if (jump)     return SEL_ADDR;
    else               return SEL_PC4;
  endfunction

endpackage

// File: rtl/redirect_latch.sv
// Holds a redirect target that arrived while the PC could not advance.
module redirect_latch #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic            clear,
  input  logic [XLEN-1:0] target,
  output logic            pend_v,
  output logic [XLEN-1:0] pend_pc
);

  logic            pend_v_q, pend_v_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  // A newer redirect overwrites an older pending one.
  always_comb begin
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    if (clear) begin
      pend_v_d = 1'b0;
    end else if (capture) begin
      pend_v_d  = 1'b1;
      pend_pc_d = target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pend_v  = pend_v_q;
  assign pend_pc = pend_pc_q;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the PC, drives the next-PC mux select, handles
// the imem handshake, stalls, redirect flushes and the sticky halt state.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            branch_taken_i,
  input  logic            jump_reg_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            imem_ready_i,
  output logic [1:0]      next_instr_sel_o,
  output logic [XLEN-1:0] pc_o,
  output logic            imem_req_o,
  output logic            instr_valid_o,
  output logic            flush_if_o,
  output logic            flush_id_o,
  output logic            halted_o
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic            active;
  logic            redirect;
  logic            advance;
  logic            pend_v;
  logic [XLEN-1:0] pend_pc;

  // Requests are only honoured while fetching; BOOT and HALT mask everything.
  assign active   = (state_q == RUN) || (state_q == WAIT);
  assign redirect = active & (branch_taken_i | jump_reg_i | jump_i);
  assign advance  = active & imem_ready_i & ~stall_i;

  always_comb begin
    next_instr_sel_o = SEL_PC4;
    if (active) begin
      next_instr_sel_o = sel_encode(branch_taken_i, jump_reg_i, jump_i);
    end
  end

  assign flush_if_o = redirect;
  assign flush_id_o = active & branch_taken_i;

  always_comb begin
    imem_req_o = 1'b0;
    unique case (state_q)
      RUN:     imem_req_o = ~stall_i;
      WAIT:    imem_req_o = 1'b1;
      default: imem_req_o = 1'b0;
    endcase
  end

  assign instr_valid_o = imem_req_o & imem_ready_i & ~flush_if_o & ~pend_v;
  assign halted_o      = (state_q == HALT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (advance && halt_i && !branch_taken_i) begin
          state_d = HALT;
        end else if (imem_req_o && !imem_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (advance && halt_i && !branch_taken_i) begin
          state_d = HALT;
        end else if (imem_ready_i) begin
          state_d = RUN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (advance) begin
        pc_q <= pend_v ? pend_pc : next_pc_i;
      end
    end
  end

  assign pc_o = pc_q;

  redirect_latch #(
    .XLEN (XLEN)
  ) u_redirect_latch (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (redirect & ~advance),
    .clear   (advance),
    .target  (next_pc_i),
    .pend_v  (pend_v),
    .pend_pc (pend_pc)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller with RESET_PC = 0x100.
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        stall_i, halt_i, branch_taken_i, jump_reg_i, jump_i, imem_ready_i;
  logic [31:0] next_pc_i;
  logic [31:0] tgt;
  logic [1:0]  next_instr_sel_o;
  logic [31:0] pc_o;
  logic        imem_req_o, instr_valid_o, flush_if_o, flush_id_o, halted_o;

  int n_vec;
  int n_miss;

  fetch_controller #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .halt_i           (halt_i),
    .branch_taken_i   (branch_taken_i),
    .jump_reg_i       (jump_reg_i),
    .jump_i           (jump_i),
    .next_pc_i        (next_pc_i),
    .imem_ready_i     (imem_ready_i),
    .next_instr_sel_o (next_instr_sel_o),
    .pc_o             (pc_o),
    .imem_req_o       (imem_req_o),
    .instr_valid_o    (instr_valid_o),
    .flush_if_o       (flush_if_o),
    .flush_id_o       (flush_id_o),
    .halted_o         (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External next-PC mux: redirect target when any redirect input is high, else PC+4.
  always_comb begin
    if (branch_taken_i || jump_reg_i || jump_i) next_pc_i = tgt;
    else                                        next_pc_i = pc_o + 32'd4;
  end

  typedef struct {
    logic        stall, halt, br, jr, j, rdy;
    logic [31:0] tgt;
    logic [1:0]  e_sel;
    logic        e_req, e_val, e_fif, e_fid, e_hlt;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [0:27];

  function automatic vec_t v(input logic s, input logic h, input logic b, input logic r,
                             input logic j, input logic rd, input logic [31:0] t,
                             input logic [1:0] sel, input logic rq, input logic vl,
                             input logic fi, input logic fd, input logic hl,
                             input logic [31:0] pc);
    vec_t x;
    x.stall = s; x.halt = h; x.br = b; x.jr = r; x.j = j; x.rdy = rd; x.tgt = t;
    x.e_sel = sel; x.e_req = rq; x.e_val = vl; x.e_fif = fi; x.e_fid = fd;
    x.e_hlt = hl; x.e_pc = pc;
    return x;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input int i);
    stall_i = tbl[i].stall; halt_i = tbl[i].halt; branch_taken_i = tbl[i].br;
    jump_reg_i = tbl[i].jr; jump_i = tbl[i].j; imem_ready_i = tbl[i].rdy; tgt = tbl[i].tgt;
    #1;
    n_vec++;
    check("sel",      i, 32'(next_instr_sel_o), 32'(tbl[i].e_sel));
    check("imem_req", i, 32'(imem_req_o),       32'(tbl[i].e_req));
    check("valid",    i, 32'(instr_valid_o),    32'(tbl[i].e_val));
    check("flush_if", i, 32'(flush_if_o),       32'(tbl[i].e_fif));
    check("flush_id", i, 32'(flush_id_o),       32'(tbl[i].e_fid));
    check("halted",   i, 32'(halted_o),         32'(tbl[i].e_hlt));
    check("pc",       i, pc_o,                  tbl[i].e_pc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    //         st h  b  r  j  rd tgt           sel rq vl fi fd hl pc
    tbl[0]  = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 0, 32'h100);
    tbl[1]  = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'h100);
    tbl[2]  = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'h104);
    tbl[3]  = v(0, 0, 0, 0, 1, 1, 32'h400,      1, 1, 0, 1, 0, 0, 32'h108);
    tbl[4]  = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'h400);
    tbl[5]  = v(0, 1, 1, 0, 1, 1, 32'h200,      3, 1, 0, 1, 1, 0, 32'h404);
    tbl[6]  = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'h200);
    tbl[7]  = v(1, 0, 0, 1, 0, 1, 32'h80,       2, 0, 0, 1, 0, 0, 32'h204);
    tbl[8]  = v(1, 0, 0, 1, 0, 1, 32'h80,       2, 0, 0, 1, 0, 0, 32'h204);
    tbl[9]  = v(1, 0, 0, 1, 0, 1, 32'h80,       2, 0, 0, 1, 0, 0, 32'h204);
    tbl[10] = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 1, 0, 0, 0, 0, 32'h204);
    tbl[11] = v(0, 0, 0, 0, 1, 1, 32'h10C,      1, 1, 0, 1, 0, 0, 32'h80);
    tbl[12] = v(0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 32'h10C);
    tbl[13] = v(0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 32'h10C);
    tbl[14] = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'h10C);
    tbl[15] = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'h110);
    tbl[16] = v(1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h114);
    tbl[17] = v(1, 0, 0, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 0, 32'h114);
    tbl[18] = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'h114);
    tbl[19] = v(0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 32'h118);
    // Second segment, after the mid-WAIT reset.
    tbl[20] = v(0, 0, 0, 0, 1, 1, 32'h500,      0, 0, 0, 0, 0, 0, 32'h100);
    tbl[21] = v(0, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 1, 1, 0, 1, 0, 0, 32'h100);
    tbl[22] = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'hFFFFFFFC);
    tbl[23] = v(0, 0, 0, 0, 1, 1, 32'h1F0,      1, 1, 0, 1, 0, 0, 32'h0);
    tbl[24] = v(0, 1, 0, 0, 0, 1, 32'h0,        0, 1, 1, 0, 0, 0, 32'h1F0);
    tbl[25] = v(0, 0, 1, 0, 0, 1, 32'h300,      0, 0, 0, 0, 0, 1, 32'h1F4);
    tbl[26] = v(0, 0, 0, 0, 1, 1, 32'h600,      0, 0, 0, 0, 0, 1, 32'h1F4);
    tbl[27] = v(0, 0, 0, 0, 0, 1, 32'h0,        0, 0, 0, 0, 0, 1, 32'h1F4);

    rst_n = 1'b0;
    stall_i = 0; halt_i = 0; branch_taken_i = 0; jump_reg_i = 0; jump_i = 0;
    imem_ready_i = 1; tgt = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i <= 19; i++) apply(i);

    // Controller now sits in WAIT at 0x118; reset must act without a clock edge.
    imem_ready_i = 0;
    #2;
    n_vec++;
    check("wait_req", 100, 32'(imem_req_o), 32'h1);
    check("wait_pc",  100, pc_o,            32'h118);
    rst_n = 1'b0;
    #1;
    n_vec++;
    check("rst_pc",     101, pc_o,               32'h100);
    check("rst_req",    101, 32'(imem_req_o),    32'h0);
    check("rst_valid",  101, 32'(instr_valid_o), 32'h0);
    check("rst_halted", 101, 32'(halted_o),      32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 20; i <= 27; i++) apply(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
